// File: rtl/icache_direct_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
// The line size is tied to the memory controller's fetch burst length.
package icache_direct_pkg;

  localparam int ADDR_WID             = 32;
  localparam int INST_WID             = 32;
  localparam int MEM_CTRL_IF_DATA_LEN = 16;
  localparam int ICACHE_LINE_BYTES    = MEM_CTRL_IF_DATA_LEN;
  localparam int ICACHE_LINES         = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MISS,
    ST_RESP
  } icache_state_e;

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Combinational lookup of one line; synchronous whole-line fill.
module icache_line_array
  import icache_direct_pkg::*;
#(
  parameter int LINE_BYTES = ICACHE_LINE_BYTES,
  parameter int LINES      = ICACHE_LINES,
  parameter int IDX_W      = $clog2(ICACHE_LINES),
  parameter int TAG_W      = ADDR_WID - $clog2(ICACHE_LINES) - $clog2(ICACHE_LINE_BYTES),
  parameter int WSEL_W     = $clog2(ICACHE_LINE_BYTES) - 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IDX_W-1:0]        rd_index,
  input  logic [TAG_W-1:0]        rd_tag,
  input  logic [WSEL_W-1:0]       rd_word,
  output logic                    rd_hit,
  output logic [INST_WID-1:0]     rd_inst,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_index,
  input  logic [TAG_W-1:0]        wr_tag,
  input  logic [LINE_BYTES*8-1:0] wr_data
);

  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [LINE_BYTES*8-1:0] data_q [LINES];
  logic [LINE_BYTES*8-1:0] rd_line;

  // NOTE: only the valid bits take reset; tag and data stay un-reset so they
  // can map onto plain RAM, and a cleared valid bit makes their contents moot.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_hit  = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
  assign rd_line = data_q[rd_index];
  assign rd_inst = rd_line[{rd_word, 5'd0} +: INST_WID];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, whole-line refill
// from the memory controller on a miss, rollback cancels pending answers.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int LINE_BYTES = ICACHE_LINE_BYTES,
  parameter int LINES      = ICACHE_LINES,
  parameter int ADDR_W     = ADDR_WID
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic                    if_req,
  input  logic [ADDR_W-1:0]       if_pc,
  output logic                    if_ready,
  output logic                    inst_valid,
  output logic [INST_WID-1:0]     inst,
  output logic [ADDR_W-1:0]       inst_pc,
  output logic                    mc_en,
  output logic [ADDR_W-1:0]       mc_pc,
  input  logic                    mc_done,
  input  logic [LINE_BYTES*8-1:0] mc_data
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WORDS  = LINE_BYTES / 4;
  localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  icache_state_e         state_q, state_d;
  logic                  pend_q, pend_d;
  logic [ADDR_W-1:0]     req_pc_q, req_pc_d;
  logic                  inst_valid_d;
  logic [INST_WID-1:0]   inst_d;
  logic [ADDR_W-1:0]     inst_pc_d;
  logic                  mc_en_d;
  logic [ADDR_W-1:0]     mc_pc_d;
  logic                  fill;

  logic [ADDR_W-1:0]     lookup_pc;
  logic [WSEL_W-1:0]     lk_word;
  logic                  lk_hit;
  logic [INST_WID-1:0]   lk_inst;

  assign if_ready = (state_q == ST_IDLE) && !rollback;

  // Outside IDLE the only lookup needed is the word of the line being refilled.
  assign lookup_pc = (state_q == ST_IDLE) ? if_pc : req_pc_q;
  assign lk_word   = WSEL_W'((lookup_pc >> 2) & ADDR_W'(WORDS - 1));

  icache_line_array #(
    .LINE_BYTES (LINE_BYTES),
    .LINES      (LINES),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W),
    .WSEL_W     (WSEL_W)
  ) u_lines (
    .clk      (clk),
    .rst      (rst),
    .rd_index (lookup_pc[OFF_W +: IDX_W]),
    .rd_tag   (lookup_pc[ADDR_W-1 -: TAG_W]),
    .rd_word  (lk_word),
    .rd_hit   (lk_hit),
    .rd_inst  (lk_inst),
    .wr_en    (fill && rdy && !rst),
    .wr_index (req_pc_q[OFF_W +: IDX_W]),
    .wr_tag   (req_pc_q[ADDR_W-1 -: TAG_W]),
    .wr_data  (mc_data)
  );

  // NOTE: every signal this block drives gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    req_pc_d     = req_pc_q;
    inst_valid_d = 1'b0;
    inst_d       = inst;
    inst_pc_d    = inst_pc;
    mc_en_d      = mc_en;
    mc_pc_d      = mc_pc;
    fill         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (if_req && if_ready) begin
          if (lk_hit) begin
            inst_valid_d = 1'b1;
            inst_d       = lk_inst;
            inst_pc_d    = if_pc;
          end else begin
            req_pc_d = if_pc;
            pend_d   = 1'b1;
            mc_en_d  = 1'b1;
            mc_pc_d  = {if_pc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            state_d  = ST_MISS;
          end
        end
      end
      ST_MISS: begin
        // A flush only cancels the answer; the burst still runs to completion.
        if (rollback) pend_d = 1'b0;
        if (mc_done) begin
          fill    = 1'b1;
          mc_en_d = 1'b0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (pend_q && !rollback) begin
          inst_valid_d = 1'b1;
          inst_d       = lk_inst;
          inst_pc_d    = req_pc_q;
        end
        pend_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pend_q     <= 1'b0;
      req_pc_q   <= '0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      mc_en      <= 1'b0;
      mc_pc      <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      req_pc_q   <= req_pc_d;
      inst_valid <= inst_valid_d;
      inst       <= inst_d;
      inst_pc    <= inst_pc_d;
      mc_en      <= mc_en_d;
      mc_pc      <= mc_pc_d;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios plus random fetches
// against a tag-store model and a behavioural memory controller.
module tb_icache_direct;

  logic         clk = 1'b0;
  logic         rst, rdy, rollback, if_req, if_ready;
  logic [31:0]  if_pc;
  logic         inst_valid;
  logic [31:0]  inst, inst_pc;
  logic         mc_en, mc_done;
  logic [31:0]  mc_pc;
  logic [127:0] mc_data;

  int vectors     = 0;
  int miscompares = 0;
  int n_deliv     = 0;
  int mc_lat      = 20;

  // Model of cache contents: which line currently holds which tag.
  bit          mv [64];
  logic [21:0] mt [64];

  icache_direct dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .rollback   (rollback),
    .if_req     (if_req),
    .if_pc      (if_pc),
    .if_ready   (if_ready),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .mc_en      (mc_en),
    .mc_pc      (mc_pc),
    .mc_done    (mc_done),
    .mc_data    (mc_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24];
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    logic [31:0] a;
    a = {pc[31:2], 2'b00};
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] base);
    logic [127:0] l;
    for (int i = 0; i < 16; i++) l[8*i +: 8] = mem_byte(base + 32'(i));
    return l;
  endfunction

  // An instruction is consumed when it is valid in a cycle the pipeline is ready.
  always @(negedge clk) if (inst_valid && rdy) n_deliv++;

  // Memory controller: serves a line mc_lat ready-cycles after mc_en, one-cycle done.
  initial begin : mem_ctrl
    int cnt;
    bit busy;
    cnt = 0; busy = 0; mc_done = 1'b0; mc_data = '0;
    forever begin
      @(posedge clk); #3;
      if (mc_done) mc_done = 1'b0;
      else if (mc_en && !rst) begin
        if (!busy) begin busy = 1; cnt = 0; mc_data = mem_line(mc_pc); end
        if (rdy) cnt++;
        if (rdy && cnt >= mc_lat) begin mc_done = 1'b1; busy = 0; end
      end else busy = 0;
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mv[i] = 0;
  endtask

  // One fetch, classified hit/miss by the model; optional rollback during the
  // refill (rb_after), in the answer cycle (rb_resp), or a 5-cycle stall.
  task automatic run_fetch(input string name, input logic [31:0] pc,
                           input int rb_after, input bit rb_resp, input int stall_at);
    logic [5:0]  idx;
    logic [21:0] tag;
    logic [31:0] line_pc;
    bit hit, done_seen, hold_bad, ready_bad, rb_fired, exp_del;
    int d0;
    idx = pc[9:4]; tag = pc[31:10]; line_pc = {pc[31:4], 4'h0};
    hit = mv[idx] && (mt[idx] == tag);
    d0 = n_deliv;
    if_req = 1'b1; if_pc = pc; #1;
    vectors++;
    if (if_ready !== 1'b1) begin
      miscompares++; $display("FAIL %s_if_ready got %b want 1", name, if_ready);
    end
    tick();
    if_req = 1'b0; if_pc = $urandom;
    if (hit) begin
      exp_del = 1;
      vectors++;
      if (inst_valid !== 1'b1 || inst !== mem_word(pc) || inst_pc !== pc || mc_en !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_hit got v=%b inst=%h pc=%h mc_en=%b want v=1 inst=%h pc=%h mc_en=0",
                 name, inst_valid, inst, inst_pc, mc_en, mem_word(pc), pc);
      end
    end else begin
      vectors++;
      if (mc_en !== 1'b1 || mc_pc !== line_pc) begin
        miscompares++;
        $display("FAIL %s_mc_req got en=%b pc=%h want en=1 pc=%h", name, mc_en, mc_pc, line_pc);
      end
      done_seen = 0; hold_bad = 0; ready_bad = 0; rb_fired = 0;
      for (int k = 0; k < 300 && !done_seen; k++) begin
        rdy = !(stall_at >= 0 && k >= stall_at && k < stall_at + 5);
        rollback = (k == rb_after);
        if (rollback && rdy) rb_fired = 1;
        if (if_ready !== 1'b0 || inst_valid !== 1'b0) ready_bad = 1;
        tick();
        if (mc_done === 1'b1) done_seen = 1;
        else if (mc_en !== 1'b1 || mc_pc !== line_pc) hold_bad = 1;
      end
      rollback = 1'b0; rdy = 1'b1;
      vectors++;
      if (!done_seen || hold_bad || ready_bad) begin
        miscompares++;
        $display("FAIL %s_miss_wait got done=%b hold_bad=%b busy_bad=%b want 1 0 0",
                 name, done_seen, hold_bad, ready_bad);
      end
      vectors++;
      if (mc_en !== 1'b0 || if_ready !== 1'b0 || inst_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_post_done got mc_en=%b if_ready=%b v=%b want 0 0 0",
                 name, mc_en, if_ready, inst_valid);
      end
      exp_del = !rb_fired && !rb_resp;
      rollback = rb_resp;
      tick();
      rollback = 1'b0;
      vectors++;
      if (inst_valid !== exp_del || (exp_del && (inst !== mem_word(pc) || inst_pc !== pc))) begin
        miscompares++;
        $display("FAIL %s_answer got v=%b inst=%h pc=%h want v=%b inst=%h pc=%h",
                 name, inst_valid, inst, inst_pc, exp_del, mem_word(pc), pc);
      end
      mv[idx] = 1; mt[idx] = tag;
    end
    tick();
    vectors++;
    if ((n_deliv - d0) != int'(exp_del) || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_count got %0d deliveries v=%b want %0d v=0",
               name, n_deliv - d0, inst_valid, exp_del);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; if_req = 1'b0; if_pc = '0;
    repeat (2) tick();
    vectors++;
    if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_inst got v=%b inst=%h pc=%h want 0 0 0", inst_valid, inst, inst_pc);
    end
    vectors++;
    if (mc_en !== 1'b0 || mc_pc !== 32'h0 || if_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mc got en=%b pc=%h if_ready=%b want 0 0 1", mc_en, mc_pc, if_ready);
    end
    rst = 1'b0;
    model_clear();
    tick();
  endtask

  task automatic test_cold_miss();
    mc_lat = 20;
    run_fetch("cold", 32'h0000_0008, -1, 0, -1);
    vectors++;
    if (inst !== 32'h0B0A_0908 || inst_pc !== 32'h8) begin
      miscompares++;
      $display("FAIL cold_word got inst=%h pc=%h want 0b0a0908 8", inst, inst_pc);
    end
  endtask

  task automatic test_hit_stream();
    int d0;
    logic [31:0] want;
    d0 = n_deliv;
    for (int i = 0; i < 4; i++) begin
      if_req = 1'b1; if_pc = 32'(4 * i);
      tick();
      want = 32'h0302_0100 + 32'h0404_0404 * 32'(i);
      vectors++;
      if (inst_valid !== 1'b1 || inst !== want || inst_pc !== 32'(4 * i) || mc_en !== 1'b0) begin
        miscompares++;
        $display("FAIL stream_%0d got v=%b inst=%h pc=%h mc_en=%b want v=1 inst=%h pc=%h mc_en=0",
                 i, inst_valid, inst, inst_pc, mc_en, want, 4 * i);
      end
    end
    if_req = 1'b0;
    tick();
    vectors++;
    if (n_deliv - d0 != 4) begin
      miscompares++;
      $display("FAIL stream_count got %0d want 4", n_deliv - d0);
    end
  endtask

  task automatic test_conflict();
    mc_lat = 5;
    run_fetch("evict", 32'h0000_0400, -1, 0, -1);
    run_fetch("refetch0", 32'h0000_0000, -1, 0, -1);
  endtask

  task automatic test_rollback();
    if_req = 1'b1; if_pc = 32'h4; rollback = 1'b1; #1;
    vectors++;
    if (if_ready !== 1'b0) begin
      miscompares++; $display("FAIL rb_same_ready got %b want 0", if_ready);
    end
    tick();
    if_req = 1'b0; rollback = 1'b0;
    vectors++;
    if (inst_valid !== 1'b0 || mc_en !== 1'b0) begin
      miscompares++;
      $display("FAIL rb_same_drop got v=%b mc_en=%b want 0 0", inst_valid, mc_en);
    end
    tick();
    mc_lat = 10;
    run_fetch("rb_refill", 32'h0000_1230, 3, 0, -1);
    run_fetch("rb_rehit", 32'h0000_1234, -1, 0, -1);
    run_fetch("rb_resp", 32'h0000_2040, -1, 1, -1);
  endtask

  task automatic test_stall();
    int d0;
    bit bad;
    d0 = n_deliv; bad = 0;
    if_req = 1'b1; if_pc = 32'h0000_1238;
    tick();
    if_req = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (inst_valid !== 1'b1 || inst !== mem_word(32'h1238) || inst_pc !== 32'h1238) bad = 1;
      tick();
    end
    rdy = 1'b1;
    vectors++;
    if (bad || inst_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_hold got v=%b inst=%h want v=1 inst=%h", inst_valid, inst,
               mem_word(32'h1238));
    end
    tick();
    vectors++;
    if (inst_valid !== 1'b0 || n_deliv - d0 != 1) begin
      miscompares++;
      $display("FAIL stall_once got v=%b deliveries=%0d want 0 1", inst_valid, n_deliv - d0);
    end
    mc_lat = 6;
    run_fetch("stall_miss", 32'h0000_3000, -1, 0, 2);
  endtask

  task automatic test_reset_mid();
    mc_lat = 20;
    if_req = 1'b1; if_pc = 32'h0000_5000;
    tick();
    if_req = 1'b0;
    vectors++;
    if (mc_en !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_req got mc_en=%b want 1", mc_en);
    end
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    vectors++;
    if (mc_en !== 1'b0 || if_ready !== 1'b1 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_state got mc_en=%b if_ready=%b v=%b want 0 1 0", mc_en, if_ready, inst_valid);
    end
    model_clear();
    tick();
    mc_lat = 4;
    run_fetch("post_rst", 32'h0000_1234, -1, 0, -1);
  endtask

  task automatic test_random();
    logic [21:0] tags [3];
    logic [31:0] pc;
    int rb, st;
    bit rr;
    tags[0] = 22'h0; tags[1] = 22'h1; tags[2] = 22'h3A_5C3;
    for (int n = 0; n < 60; n++) begin
      mc_lat = $urandom_range(1, 6);
      pc = {tags[$urandom_range(0, 2)], 6'($urandom_range(0, 3) * 17), 4'($urandom)};
      rb = ($urandom_range(0, 5) == 0) ? $urandom_range(0, mc_lat) : -1;
      rr = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
      run_fetch("rand", pc, rb, rr, st);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_stream();
    test_conflict();
    test_rollback();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
